reservation_station: RTL
========================

Name: reservation_station

Overview:
- Out-of-order issue buffer for non-load/store instructions.
- Sits between the dispatch stage (upstream, registered rs_* outputs) and the ALU (downstream).
- Each entry holds an operation, two operands and the entry's ROB tag.
- Pending operands are woken by CDB broadcasts; the oldest-slot ready entry is sent to the ALU, one per cycle.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥4).
- RS_IDX_W, 3, log2(RS_SIZE).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = freeze all state
- rb  in  1  rollback (mispredict flush)
- rs_full  out  1  dispatch back-pressure
- rs_ena  in  1  dispatch write strobe
- rs_opt  in  INST_OPT_W  operation code
- rs_src1, rs_src2  in  ROB_IDX_W  producer tag per operand; ZERO_ROB_IDX = value already valid
- rs_val1, rs_val2  in  32  operand values, valid when tag is zero
- rs_imm  in  32  immediate
- rs_rob_idx  in  ROB_IDX_W  destination ROB tag
- cdb_alu_valid, cdb_ld_valid  in  1  CDB broadcast valids
- cdb_alu_src, cdb_ld_src  in  ROB_IDX_W  broadcast tags
- cdb_alu_val, cdb_ld_val  in  32  broadcast values
- alu_ena  out  1  issue strobe, one-cycle pulse
- alu_opt  out  INST_OPT_W
- alu_val1, alu_val2, alu_imm  out  32
- alu_rob_idx  out  ROB_IDX_W

Behaviour:
- Per entry: busy, opt, src1, src2, val1, val2, imm, rob_idx.
- Entry is ready when busy && src1==0 && src2==0.
- Reset (rst high at posedge):
  - All busy cleared.
  - alu_ena=0; alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx = 0.
  - rs_full=0.
  - rst has priority over rdy and rb.
- rdy low: no state changes at all. alu_ena holds its value; downstream also gates on rdy.
- rb high (rdy high, no rst):
  - All busy cleared; alu_ena=0 next cycle.
  - An rs_ena in the same cycle is dropped.
- Normal cycle (rdy high, no rst, no rb). All of the following happen at the same posedge:
  - Default alu_ena=0.
  - Issue: select the lowest-index ready entry based on state before this edge. Drive alu_* from it, set alu_ena=1, clear its busy.
  - Latency: an entry written at edge t is eligible at edge t+1 at the earliest. Issue results are visible one cycle after selection.
  - Write: on rs_ena, fill the lowest-index non-busy slot.
  - Write-time wakeup: incoming operands are compared against this cycle's CDB. On a match with a nonzero tag, store val=CDB value and src=0. ALU bus is checked before the LD bus.
  - Wakeup of stored entries: for every busy entry and each operand with nonzero src, on a match with cdb_alu_src (if valid) or cdb_ld_src (if valid), latch the value and set src=0.
  - Woken entries become eligible at the next edge.
  - The slot freed by issue this cycle is not reusable for this cycle's write.
- rs_full:
  - Registered: 1 when occupancy after the edge ≥ RS_SIZE-1.
  - Dispatch has a one-cycle registered path, so one write may already be in flight when full rises. That write must always find a free slot (never overflows).
  - rs_ena arriving with no free slot is an error: assertion in simulation, write dropped.
- Tag 0 never matches a CDB broadcast. The ROB never broadcasts tag 0.
- Both CDB buses carrying the same tag in one cycle cannot occur; ALU wins if it does.

Decomposition:
- Shared constants in the existing utils include: WORD width, ROB_IDX_W, INST_OPT_W, ZERO_ROB_IDX, ZERO_WORD, TRUE/FALSE.
- RS_SIZE and RS_IDX_W are added there for reuse by the dispatcher.
- One sub-module, rs_prio_enc:
  - Parameterised lowest-index priority encoder: RS_SIZE-bit mask in, index out, plus a found flag.
  - Instantiated twice: once on ~busy for the free slot, once on the ready mask for issue.

Test Plan:
- Basic issue: write opt=ADD, src1=src2=0, val1=5, val2=7, rob_idx=3 at edge t -> at edge t+1 alu_ena=1, alu_val1=5, alu_val2=7, alu_rob_idx=3; alu_ena=0 at t+2.
- Wakeup: write src1=4 at t. Then cdb_alu_valid=1, src=4, val=0x1234 at t+2 -> no issue before t+3; at t+3 alu_val1=0x1234.
- Same-cycle wakeup on write: rs_ena with src2=6 while cdb_ld_valid=1, src=6, val=0xABCD -> entry issues at next edge with alu_val2=0xABCD.
- Full/back-pressure (RS_SIZE=8): 7 writes of entries blocked on tag 9 -> rs_full=1 after the 7th. The 8th in-flight write is accepted. A broadcast of tag 9 then drains one entry per cycle, lowest slot first; rs_full falls when occupancy ≤6.
- Rollback: 3 blocked entries plus rs_ena and rb in the same cycle -> all busy=0, alu_ena=0. A later broadcast of their tag causes no issue.
- rdy/rst: rdy low for 3 cycles with a ready entry -> no issue and state frozen; issue one edge after rdy rises. rst mid-stream -> all outputs zero, rs_full=0.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared constants, entry/operand types and the CDB wakeup helper used by the
// reservation station and the dispatcher.
package reservation_station_pkg;

    localparam int WORD_W     = 32;
    localparam int ROB_IDX_W  = 4;
    localparam int INST_OPT_W = 4;
    localparam int RS_SIZE    = 8;
    localparam int RS_IDX_W   = $clog2(RS_SIZE);

    localparam logic [ROB_IDX_W-1:0] ZERO_ROB_IDX = {ROB_IDX_W{1'b0}};
    localparam logic [WORD_W-1:0]    ZERO_WORD    = {WORD_W{1'b0}};
    localparam logic                 TRUE         = 1'b1;
    localparam logic                 FALSE        = 1'b0;

    typedef enum logic [INST_OPT_W-1:0] {
        OPT_ADD = 4'd0,
        OPT_SUB = 4'd1,
        OPT_AND = 4'd2,
        OPT_OR  = 4'd3,
        OPT_XOR = 4'd4,
        OPT_SLL = 4'd5,
        OPT_SRL = 4'd6,
        OPT_SLT = 4'd7
    } inst_opt_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] src;
        logic [WORD_W-1:0]    val;
    } operand_t;

    typedef struct packed {
        logic                  busy;
        logic [INST_OPT_W-1:0] opt;
        operand_t              op1;
        operand_t              op2;
        logic [WORD_W-1:0]     imm;
        logic [ROB_IDX_W-1:0]  rob_idx;
    } rs_entry_t;

    localparam rs_entry_t RS_ENTRY_EMPTY = rs_entry_t'({$bits(rs_entry_t){1'b0}});

    // A pending operand captures a CDB value on tag match; ALU bus wins over LD.
    function automatic operand_t wake_op(
        input operand_t             op,
        input logic                 alu_valid,
        input logic [ROB_IDX_W-1:0] alu_src,
        input logic [WORD_W-1:0]    alu_val,
        input logic                 ld_valid,
        input logic [ROB_IDX_W-1:0] ld_src,
        input logic [WORD_W-1:0]    ld_val
    );
        operand_t res;
        res = op;
        if (op.src != ZERO_ROB_IDX) begin
            if (alu_valid && (alu_src == op.src)) begin
                res.src = ZERO_ROB_IDX;
                res.val = alu_val;
            end else if (ld_valid && (ld_src == op.src)) begin
                res.src = ZERO_ROB_IDX;
                res.val = ld_val;
            end else begin
                res = op;
            end
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and ALU-issue signals of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                  rs_full;
    logic                  rs_ena;
    logic [INST_OPT_W-1:0] rs_opt;
    logic [ROB_IDX_W-1:0]  rs_src1;
    logic [ROB_IDX_W-1:0]  rs_src2;
    logic [WORD_W-1:0]     rs_val1;
    logic [WORD_W-1:0]     rs_val2;
    logic [WORD_W-1:0]     rs_imm;
    logic [ROB_IDX_W-1:0]  rs_rob_idx;

    logic                  cdb_alu_valid;
    logic [ROB_IDX_W-1:0]  cdb_alu_src;
    logic [WORD_W-1:0]     cdb_alu_val;
    logic                  cdb_ld_valid;
    logic [ROB_IDX_W-1:0]  cdb_ld_src;
    logic [WORD_W-1:0]     cdb_ld_val;

    logic                  alu_ena;
    logic [INST_OPT_W-1:0] alu_opt;
    logic [WORD_W-1:0]     alu_val1;
    logic [WORD_W-1:0]     alu_val2;
    logic [WORD_W-1:0]     alu_imm;
    logic [ROB_IDX_W-1:0]  alu_rob_idx;

    modport master (
        input  rs_full,
        output rs_ena, rs_opt, rs_src1, rs_src2, rs_val1, rs_val2, rs_imm, rs_rob_idx,
        output cdb_alu_valid, cdb_alu_src, cdb_alu_val,
        output cdb_ld_valid, cdb_ld_src, cdb_ld_val,
        input  alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx
    );

    modport slave (
        output rs_full,
        input  rs_ena, rs_opt, rs_src1, rs_src2, rs_val1, rs_val2, rs_imm, rs_rob_idx,
        input  cdb_alu_valid, cdb_alu_src, cdb_alu_val,
        input  cdb_ld_valid, cdb_ld_src, cdb_ld_val,
        output alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx
    );

endinterface

// File: rtl/reservation_station_checker.sv
// Simulation-only checks on the reservation station dispatch contract.
module reservation_station_checker (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic rb,
    input logic rs_ena,
    input logic free_found
);

    // A dispatch write must always find a free slot; back-pressure leaves one spare.
    always @(posedge clk) begin
        if (!rst && rdy && !rb && rs_ena) begin
            assert (free_found)
                else $error("reservation_station: dispatch write with no free slot, write dropped");
        end
    end

endmodule

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index priority encoder: reports the first set bit of the mask.
module rs_prio_enc
    import reservation_station_pkg::*;
#(
    parameter int N = RS_SIZE,
    parameter int W = RS_IDX_W
) (
    input  logic [N-1:0] mask_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = {W{1'b0}};
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer for ALU instructions: captures dispatched ops,
// wakes operands from both CDB buses and issues the lowest ready slot per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    input logic                  rdy,
    input logic                  rb,
    reservation_station_if.slave bus
);

    rs_entry_t             entries_q [RS_SIZE];
    rs_entry_t             entries_d [RS_SIZE];
    logic                  alu_ena_q,     alu_ena_d;
    logic [INST_OPT_W-1:0] alu_opt_q,     alu_opt_d;
    logic [WORD_W-1:0]     alu_val1_q,    alu_val1_d;
    logic [WORD_W-1:0]     alu_val2_q,    alu_val2_d;
    logic [WORD_W-1:0]     alu_imm_q,     alu_imm_d;
    logic [ROB_IDX_W-1:0]  alu_rob_idx_q, alu_rob_idx_d;
    logic                  rs_full_q,     rs_full_d;

    logic [RS_SIZE-1:0]    free_mask_s;
    logic [RS_SIZE-1:0]    ready_mask_s;
    logic [RS_IDX_W-1:0]   free_idx_s;
    logic [RS_IDX_W-1:0]   issue_idx_s;
    logic                  free_found_s;
    logic                  issue_found_s;
    logic [RS_IDX_W:0]     occ_s;
    operand_t              in_op1_s;
    operand_t              in_op2_s;

    // Slot status as seen before this edge.
    always_comb begin
        free_mask_s  = {RS_SIZE{1'b0}};
        ready_mask_s = {RS_SIZE{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            free_mask_s[i]  = ~entries_q[i].busy;
            ready_mask_s[i] = entries_q[i].busy
                              && (entries_q[i].op1.src == ZERO_ROB_IDX)
                              && (entries_q[i].op2.src == ZERO_ROB_IDX);
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
        .mask_i  (free_mask_s),
        .idx_o   (free_idx_s),
        .found_o (free_found_s)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_enc (
        .mask_i  (ready_mask_s),
        .idx_o   (issue_idx_s),
        .found_o (issue_found_s)
    );

    assign in_op1_s = wake_op({bus.rs_src1, bus.rs_val1},
                              bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                              bus.cdb_ld_valid,  bus.cdb_ld_src,  bus.cdb_ld_val);
    assign in_op2_s = wake_op({bus.rs_src2, bus.rs_val2},
                              bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                              bus.cdb_ld_valid,  bus.cdb_ld_src,  bus.cdb_ld_val);

    // Next state: flush, or wakeup + issue + write, then occupancy for back-pressure.
    always_comb begin
        entries_d     = entries_q;
        alu_ena_d     = 1'b0;
        alu_opt_d     = alu_opt_q;
        alu_val1_d    = alu_val1_q;
        alu_val2_d    = alu_val2_q;
        alu_imm_d     = alu_imm_q;
        alu_rob_idx_d = alu_rob_idx_q;

        if (rb) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (entries_q[i].busy) begin
                    entries_d[i].op1 = wake_op(entries_q[i].op1,
                        bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                        bus.cdb_ld_valid,  bus.cdb_ld_src,  bus.cdb_ld_val);
                    entries_d[i].op2 = wake_op(entries_q[i].op2,
                        bus.cdb_alu_valid, bus.cdb_alu_src, bus.cdb_alu_val,
                        bus.cdb_ld_valid,  bus.cdb_ld_src,  bus.cdb_ld_val);
                end else begin
                    entries_d[i] = entries_q[i];
                end
            end

            if (issue_found_s) begin
                alu_ena_d                   = 1'b1;
                alu_opt_d                   = entries_q[issue_idx_s].opt;
                alu_val1_d                  = entries_q[issue_idx_s].op1.val;
                alu_val2_d                  = entries_q[issue_idx_s].op2.val;
                alu_imm_d                   = entries_q[issue_idx_s].imm;
                alu_rob_idx_d               = entries_q[issue_idx_s].rob_idx;
                entries_d[issue_idx_s].busy = 1'b0;
            end else begin
                alu_ena_d = 1'b0;
            end

            // The free slot comes from pre-edge busy, so a slot issuing now is not reused.
            if (bus.rs_ena && free_found_s) begin
                entries_d[free_idx_s].busy    = 1'b1;
                entries_d[free_idx_s].opt     = bus.rs_opt;
                entries_d[free_idx_s].op1     = in_op1_s;
                entries_d[free_idx_s].op2     = in_op2_s;
                entries_d[free_idx_s].imm     = bus.rs_imm;
                entries_d[free_idx_s].rob_idx = bus.rs_rob_idx;
            end else begin
                entries_d[free_idx_s] = entries_d[free_idx_s];
            end
        end

        occ_s = {(RS_IDX_W + 1){1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            occ_s = occ_s + {{RS_IDX_W{1'b0}}, entries_d[i].busy};
        end
        rs_full_d = (occ_s >= (RS_IDX_W + 1)'(RS_SIZE - 1));
    end

    // State and registered outputs; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= RS_ENTRY_EMPTY;
            end
            alu_ena_q     <= 1'b0;
            alu_opt_q     <= {INST_OPT_W{1'b0}};
            alu_val1_q    <= ZERO_WORD;
            alu_val2_q    <= ZERO_WORD;
            alu_imm_q     <= ZERO_WORD;
            alu_rob_idx_q <= ZERO_ROB_IDX;
            rs_full_q     <= 1'b0;
        end else if (rdy) begin
            entries_q     <= entries_d;
            alu_ena_q     <= alu_ena_d;
            alu_opt_q     <= alu_opt_d;
            alu_val1_q    <= alu_val1_d;
            alu_val2_q    <= alu_val2_d;
            alu_imm_q     <= alu_imm_d;
            alu_rob_idx_q <= alu_rob_idx_d;
            rs_full_q     <= rs_full_d;
        end
    end

    assign bus.rs_full     = rs_full_q;
    assign bus.alu_ena     = alu_ena_q;
    assign bus.alu_opt     = alu_opt_q;
    assign bus.alu_val1    = alu_val1_q;
    assign bus.alu_val2    = alu_val2_q;
    assign bus.alu_imm     = alu_imm_q;
    assign bus.alu_rob_idx = alu_rob_idx_q;

    reservation_station_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rb         (rb),
        .rs_ena     (bus.rs_ena),
        .free_found (free_found_s)
    );

endmodule
